// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART transmit/receive path.
package uart_pkg;

  localparam int BYTE_W      = 8;
  localparam int AES_BLOCK_W = 128;

  // Block serializer control states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_GAP,
    ST_DONE
  } tx_state_e;

endpackage

// File: rtl/tx_serializer.sv
// Serializes one block into bytes for the UART transmitter, MSB byte first,
// pacing on tx_done with an optional idle gap between bytes.
module tx_serializer
  import uart_pkg::*;
#(
  parameter int NBYTES     = AES_BLOCK_W / BYTE_W,
  parameter int GAP_CYCLES = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NBYTES*BYTE_W-1:0] block_in,
  input  logic                     block_valid,
  output logic                     ready,
  output logic [BYTE_W-1:0]        tx_data,
  output logic                     tx_start,
  input  logic                     tx_done,
  output logic                     done,
  output logic                     drop
);

  localparam int BLK_W = NBYTES * BYTE_W;
  localparam int CNT_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  tx_state_e         state;
  logic [BLK_W-1:0]  shreg;
  logic [BLK_W-1:0]  shreg_shl;
  logic [CNT_W-1:0]  byte_cnt;
  logic [GAP_W-1:0]  gap_cnt;

  // Register contents after dropping the byte just sent; its top byte is next.
  assign shreg_shl = shreg << BYTE_W;

  // Control FSM with registered handshake outputs and byte datapath.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      // NOTE: the shift register is a plain register, not a memory, so it is
      // cleared with everything else; a reset mid-block leaves no stale data.
      shreg    <= '0;
      byte_cnt <= '0;
      gap_cnt  <= '0;
      ready    <= 1'b1;
      tx_data  <= '0;
      tx_start <= 1'b0;
      done     <= 1'b0;
      drop     <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so every branch reads the pre-edge
      // values of state/shreg and the defaults below are safely overridden.
      tx_start <= 1'b0;
      done     <= 1'b0;
      drop     <= block_valid && (state != ST_IDLE);

      case (state)
        ST_IDLE: begin
          if (block_valid) begin
            shreg    <= block_in;
            byte_cnt <= '0;
            tx_data  <= block_in[BLK_W-1 -: BYTE_W];
            tx_start <= 1'b1;
            ready    <= 1'b0;
            state    <= ST_START;
          end
        end

        ST_START: begin
          // tx_done in this cycle belongs to no byte of ours and is ignored.
          state <= ST_WAIT;
        end

        ST_WAIT: begin
          if (tx_done) begin
            if (byte_cnt == LAST_BYTE) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              shreg    <= shreg_shl;
              byte_cnt <= byte_cnt + 1'b1;
              if (GAP_CYCLES > 0) begin
                gap_cnt <= GAP_LOAD;
                state   <= ST_GAP;
              end else begin
                tx_data  <= shreg_shl[BLK_W-1 -: BYTE_W];
                tx_start <= 1'b1;
                state    <= ST_START;
              end
            end
          end
        end

        ST_GAP: begin
          // tx_data keeps the previous byte until the next tx_start.
          if (gap_cnt == '0) begin
            tx_data  <= shreg[BLK_W-1 -: BYTE_W];
            tx_start <= 1'b1;
            state    <= ST_START;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end

        ST_DONE: begin
          ready <= 1'b1;
          state <= ST_IDLE;
        end

        default: begin
          ready <= 1'b1;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_serializer.sv
// Self-checking bench for tx_serializer: one instance back-to-back, one with
// a 3-cycle inter-byte gap, each driven by a UART_tx model that answers
// tx_start with tx_done 20 cycles later.
module tb_tx_serializer;

  localparam int NB   = 16;
  localparam int BW   = 128;
  localparam int RESP = 20;
  localparam int GAP3 = 3;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  // Instance with GAP_CYCLES = 0
  logic [BW-1:0] blk0;
  logic          valid0;
  logic          ready0;
  logic [7:0]    data0;
  logic          start0;
  logic          tx_done0 = 1'b0;
  logic          done0;
  logic          drop0;

  // Instance with GAP_CYCLES = 3
  logic [BW-1:0] blk3;
  logic          valid3;
  logic          ready3;
  logic [7:0]    data3;
  logic          start3;
  logic          tx_done3 = 1'b0;
  logic          done3;
  logic          drop3;

  tx_serializer #(.NBYTES(NB), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .block_in(blk0), .block_valid(valid0),
    .ready(ready0), .tx_data(data0), .tx_start(start0), .tx_done(tx_done0),
    .done(done0), .drop(drop0)
  );

  tx_serializer #(.NBYTES(NB), .GAP_CYCLES(GAP3)) dut3 (
    .clk(clk), .reset(reset), .block_in(blk3), .block_valid(valid3),
    .ready(ready3), .tx_data(data3), .tx_start(start3), .tx_done(tx_done3),
    .done(done3), .drop(drop3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard state, instance 0 ----------------
  logic [7:0] exp_q[$];
  logic [7:0] sent[$];
  int  exp_start      = -1;
  int  last_real_done = -1;
  int  n_start = 0, n_done = 0, n_drop = 0;
  int  resp_cnt = 0;
  bit  spur_start = 1'b0;
  bit  inj_idle   = 1'b0;
  bit  done_prev  = 1'b0;

  // ---------------- scoreboard state, instance 3 ----------------
  logic [7:0] exp3_q[$];
  int  exp_start3      = -1;
  int  last_real_done3 = -1;
  int  n_start3 = 0, n_done3 = 0;
  int  resp_cnt3 = 0;

  // UART_tx model for instance 0, plus spurious tx_done injection.
  always @(negedge clk) begin
    tx_done0 = 1'b0;
    if (reset) begin
      resp_cnt = 0;
    end else begin
      if (inj_idle) begin
        tx_done0 = 1'b1;
        inj_idle = 1'b0;
      end
      if (start0) begin
        resp_cnt = RESP;
        if (spur_start) tx_done0 = 1'b1;
      end else if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          tx_done0       = 1'b1;
          last_real_done = cyc;
          exp_start      = cyc + 1;
        end
      end
    end
  end

  // Output monitor for instance 0.
  always @(negedge clk) begin
    if (!reset) begin
      if (start0) begin
        n_start++;
        sent.push_back(data0);
        if (exp_q.size() == 0) check("start_without_byte", start0, 1'b0);
        else                   check("tx_byte", data0, exp_q.pop_front());
        check("tx_start_cycle", cyc, exp_start);
      end
      if (done0) begin
        n_done++;
        check("done_cycle", cyc, last_real_done + 1);
        check("ready_in_done", ready0, 1'b0);
      end
      if (done_prev) check("ready_after_done", ready0, 1'b1);
      done_prev = done0;
      if (drop0) n_drop++;
    end
  end

  // UART_tx model for instance 3.
  always @(negedge clk) begin
    tx_done3 = 1'b0;
    if (reset) begin
      resp_cnt3 = 0;
    end else if (start3) begin
      resp_cnt3 = RESP;
    end else if (resp_cnt3 > 0) begin
      resp_cnt3--;
      if (resp_cnt3 == 0) begin
        tx_done3        = 1'b1;
        last_real_done3 = cyc;
        exp_start3      = cyc + 1 + GAP3;
      end
    end
  end

  // Output monitor for instance 3.
  always @(negedge clk) begin
    if (!reset) begin
      if (start3) begin
        n_start3++;
        if (exp3_q.size() == 0) check("gap_start_without_byte", start3, 1'b0);
        else                    check("gap_tx_byte", data3, exp3_q.pop_front());
        check("gap_tx_start_cycle", cyc, exp_start3);
      end
      if (done3) begin
        n_done3++;
        check("gap_done_cycle", cyc, last_real_done3 + 1);
      end
    end
  end

  // Called at a negedge: queue the expected bytes and pulse block_valid.
  task automatic send0(input logic [BW-1:0] b);
    for (int i = 0; i < NB; i++) exp_q.push_back(b[BW-1-8*i -: 8]);
    exp_start = cyc + 1;
    blk0      = b;
    valid0    = 1'b1;
    @(negedge clk);
    valid0    = 1'b0;
  endtask

  task automatic wait_done0(input int budget);
    int d0 = n_done;
    int k  = 0;
    while (n_done == d0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (n_done == d0) check("done_timeout", n_done, d0 + 1);
  endtask

  typedef struct {
    logic [BW-1:0] blk;
    logic [7:0]    first;
    logic [7:0]    last;
  } vec_t;

  vec_t tbl[4];

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, n_start=%0d n_done=%0d", n_start, n_done);
    $fatal(1, "timeout");
  end

  initial begin : main
    int d, s0, k;
    tbl[0] = '{128'h00112233445566778899AABBCCDDEEFF, 8'h00, 8'hFF};
    tbl[1] = '{128'hFFEEDDCCBBAA99887766554433221100, 8'hFF, 8'h00};
    tbl[2] = '{128'h0123456789ABCDEFFEDCBA9876543210, 8'h01, 8'h10};
    tbl[3] = '{128'h80000000000000000000000000000001, 8'h80, 8'h01};

    reset  = 1'b1;
    valid0 = 1'b0;
    blk0   = '0;
    valid3 = 1'b0;
    blk3   = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_ready",    ready0, 1'b1);
    check("rst_tx_data",  data0,  8'h00);
    check("rst_tx_start", start0, 1'b0);
    check("rst_done",     done0,  1'b0);
    check("rst_drop",     drop0,  1'b0);
    check("rst_ready_gap", ready3, 1'b1);

    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Table-driven blocks, back-to-back bytes
    for (int i = 0; i < 4; i++) begin
      sent.delete();
      d = n_done;
      send0(tbl[i].blk);
      wait_done0(600);
      repeat (2) @(negedge clk);
      check("blk_done_count", n_done, d + 1);
      check("blk_bytes_left", exp_q.size(), 0);
      check("blk_bytes_sent", sent.size(), NB);
      if (sent.size() == NB) begin
        check("blk_first_byte", sent[0], tbl[i].first);
        check("blk_last_byte",  sent[NB-1], tbl[i].last);
      end
    end

    // Gap instance: 16 starts, each GAP3+1 cycles after the previous tx_done
    for (int i = 0; i < NB; i++) exp3_q.push_back(tbl[0].blk[BW-1-8*i -: 8]);
    exp_start3 = cyc + 1;
    blk3   = tbl[0].blk;
    valid3 = 1'b1;
    @(negedge clk);
    valid3 = 1'b0;
    k = 0;
    while (n_done3 == 0 && k < 800) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    check("gap_done_count",  n_done3,  1);
    check("gap_start_count", n_start3, NB);
    check("gap_ready_after", ready3,   1'b1);

    // Busy drop during byte 5: first block keeps going
    sent.delete();
    d  = n_drop;
    send0(tbl[0].blk);
    k = 0;
    while (sent.size() < 6 && k < 400) begin
      @(negedge clk);
      k++;
    end
    blk0   = 128'hFFEEDDCCBBAA99887766554433221100;
    valid0 = 1'b1;
    @(negedge clk);
    valid0 = 1'b0;
    check("busy_drop_pulse", drop0, 1'b1);
    @(negedge clk);
    check("busy_drop_clear", drop0, 1'b0);
    check("busy_drop_count", n_drop, d + 1);
    wait_done0(600);
    repeat (2) @(negedge clk);
    check("busy_bytes_sent", sent.size(), NB);
    check("busy_bytes_left", exp_q.size(), 0);

    // block_valid in the DONE cycle is dropped, not captured
    send0(tbl[2].blk);
    k = 0;
    while (!done0 && k < 600) begin
      @(negedge clk);
      k++;
    end
    check("done_seen", done0, 1'b1);
    s0     = n_start + 0;
    blk0   = tbl[3].blk;
    valid0 = 1'b1;
    @(negedge clk);
    valid0 = 1'b0;
    check("done_cycle_drop", drop0,  1'b1);
    check("done_cycle_idle", ready0, 1'b1);
    repeat (4) @(negedge clk);
    check("done_cycle_no_start", n_start, s0);

    // Spurious tx_done in IDLE and in every tx_start cycle
    inj_idle = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_spur_ready", ready0, 1'b1);
    spur_start = 1'b1;
    sent.delete();
    d = n_done;
    send0(tbl[1].blk);
    wait_done0(600);
    repeat (2) @(negedge clk);
    spur_start = 1'b0;
    check("spur_done_count", n_done, d + 1);
    check("spur_bytes_sent", sent.size(), NB);

    // Reset during byte 8, right in its tx_start cycle
    d = n_done;
    send0(tbl[0].blk);
    k  = 1;
    s0 = 0;
    while (k < 9 && s0 < 400) begin
      @(negedge clk);
      if (start0) k++;
      s0++;
    end
    check("rst_mid_at_byte8", start0, 1'b1);
    #1 reset = 1'b1;
    #1;
    check("rst_mid_tx_start", start0, 1'b0);
    check("rst_mid_ready",    ready0, 1'b1);
    check("rst_mid_tx_data",  data0,  8'h00);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check("rst_mid_no_done", n_done, d);
    sent.delete();
    send0(tbl[2].blk);
    wait_done0(600);
    repeat (2) @(negedge clk);
    check("rst_new_bytes", sent.size(), NB);
    if (sent.size() > 0) check("rst_new_first", sent[0], tbl[2].first);
    check("rst_new_done", n_done, d + 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
